// File: rtl/noise_checker.sv
// rtl/noise_checker.sv - self-synchronising checker for the 24-bit LFSR noise stream
//
// Purpose:
//    Receive-side monitor for the 24-bit LFSR noise generator
//    (next = {cur[22:0], cur[23]^cur[22]^cur[21]^cur[16]}).
//    Searches for a nonzero seed, verifies LOCK_COUNT consecutive correct
//    predictions, then counts mispredicted samples while locked.
//    Optional build macro: NOISE_CHK_BITERR_EN adds a 32-bit bit-error counter.
//
// Ports:
//    clk           in   system clock, rising edge
//    reset         in   asynchronous active-high reset
//    enable        in   sample valid strobe
//    sample        in   [23:0] incoming noise word
//    locked        out  high while in LOCKED
//    error         out  one-cycle pulse: last consumed sample mispredicted in LOCKED
//    zero_flag     out  one-cycle pulse: last consumed sample was all-zero
//    bit_err_count out  [31:0] saturating sum of wrong bits (NOISE_CHK_BITERR_EN only)
//    err_count     out  [CNT_W-1:0] saturating count of LOCKED mispredictions
//
`timescale 1ns/1ps

module noise_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [23:0]      sample,
   output logic             locked,
   output logic             error,
   output logic             zero_flag,
`ifdef NOISE_CHK_BITERR_EN
   output logic [31:0]      bit_err_count,
`endif
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
   localparam logic [3:0] MISS_TGT = 4'(MISS_LIMIT);

   state_t           r_state;
   logic [23:0]      r_prev;
   logic [3:0]       r_match;
   logic [3:0]       r_miss;
   logic             r_locked;
   logic             r_error;
   logic             r_zero;
   logic [CNT_W-1:0] r_err_count;

   logic [23:0]      w_pred;
   logic             w_zero;
   logic             w_hit;
   logic             w_locked_miss;
   logic [3:0]       w_match_inc;
   logic [3:0]       w_miss_inc;
   logic             w_err_sat;
   logic [CNT_W-1:0] w_err_inc;

   // Prediction of the current sample from the previously consumed one.
   assign w_pred      = {r_prev[22:0], r_prev[23] ^ r_prev[22] ^ r_prev[21] ^ r_prev[16]};
   assign w_zero      = (sample == 24'd0);
   assign w_hit       = (sample == w_pred);
   // After an all-zero sample prev is zero and so is the prediction; a zero
   // sample must still count as a miss, so it is excluded from a hit here.
   assign w_locked_miss = !w_hit || w_zero;
   assign w_match_inc = r_match + 4'd1;
   assign w_miss_inc  = r_miss + 4'd1;
   assign w_err_sat   = &r_err_count;
   assign w_err_inc   = r_err_count + CNT_W'(1);

`ifdef NOISE_CHK_BITERR_EN
   logic [31:0] r_bit_err;
   logic [4:0]  w_diff_bits;
   logic [32:0] w_bit_sum;

   function automatic logic [4:0] f_popcount24(input logic [23:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 24; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   assign w_diff_bits = f_popcount24(sample ^ w_pred);
   // One extra bit catches the carry so the counter can clamp at all-ones.
   assign w_bit_sum   = {1'b0, r_bit_err} + {28'd0, w_diff_bits};
   assign bit_err_count = r_bit_err;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_SEARCH;
         r_prev      <= 24'd0;
         r_match     <= 4'd0;
         r_miss      <= 4'd0;
         r_locked    <= 1'b0;
         r_error     <= 1'b0;
         r_zero      <= 1'b0;
         r_err_count <= '0;
`ifdef NOISE_CHK_BITERR_EN
         r_bit_err   <= 32'd0;
`endif
      end else begin
         // Pulse outputs default low; they only rise for a consumed sample.
         r_error <= 1'b0;
         r_zero  <= 1'b0;
         if (enable) begin
            r_prev <= sample;
            r_zero <= w_zero;
            case (r_state)
               ST_SEARCH: begin
                  if (!w_zero) begin
                     r_state <= ST_VERIFY;
                     r_match <= 4'd0;
                  end
               end
               ST_VERIFY: begin
                  if (w_zero) begin
                     r_state <= ST_SEARCH;
                     r_match <= 4'd0;
                  end else if (w_hit) begin
                     if (w_match_inc >= LOCK_TGT) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                        r_match  <= 4'd0;
                        r_miss   <= 4'd0;
                     end else begin
                        r_match <= w_match_inc;
                     end
                  end else begin
                     // Mispredict: the new sample becomes the fresh seed.
                     r_match <= 4'd0;
                  end
               end
               ST_LOCKED: begin
                  if (w_locked_miss) begin
                     r_error <= 1'b1;
                     if (!w_err_sat) begin
                        r_err_count <= w_err_inc;
                     end
`ifdef NOISE_CHK_BITERR_EN
                     if (w_bit_sum[32]) begin
                        r_bit_err <= 32'hFFFF_FFFF;
                     end else begin
                        r_bit_err <= w_bit_sum[31:0];
                     end
`endif
                     if (w_miss_inc >= MISS_TGT) begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                        r_miss   <= 4'd0;
                     end else begin
                        r_miss <= w_miss_inc;
                     end
                  end else begin
                     r_miss <= 4'd0;
                  end
               end
               default: begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
                  r_match  <= 4'd0;
                  r_miss   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign locked    = r_locked;
   assign error     = r_error;
   assign zero_flag = r_zero;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_noise_checker.sv
// tb/tb_noise_checker.sv - directed self-checking bench for noise_checker
`timescale 1ns/1ps

module tb_noise_checker;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [23:0]      sample;
   logic             locked;
   logic             error;
   logic             zero_flag;
   logic [CNT_W-1:0] err_count;
`ifdef NOISE_CHK_BITERR_EN
   logic [31:0]      bit_err_count;
`endif

   int          tests = 0;
   int          fails = 0;
   logic [23:0] cur;
   logic [23:0] held;
   logic        err_seen;

   noise_checker #(
      .LOCK_COUNT(4),
      .MISS_LIMIT(3),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .sample(sample),
      .locked(locked),
      .error(error),
      .zero_flag(zero_flag),
`ifdef NOISE_CHK_BITERR_EN
      .bit_err_count(bit_err_count),
`endif
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] nxt(input logic [23:0] x);
      return {x[22:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic en, input logic [23:0] s);
      enable = en;
      sample = s;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_good();
      step(1'b1, cur);
      cur = nxt(cur);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      sample = 24'd0;
      #3;
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_zero", {31'd0, zero_flag}, 32'd0);
      check("rst_errcnt", {28'd0, err_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Clean lock from seed 1: locked visible after the 5th sample.
      cur = 24'h000001;
      err_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         feed_good();
         err_seen |= error;
      end
      check("clean_prelock", {31'd0, locked}, 32'd0);
      feed_good();
      err_seen |= error;
      check("clean_lock", {31'd0, locked}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         feed_good();
         err_seen |= error;
      end
      check("clean_no_err", {31'd0, err_seen}, 32'd0);
      check("clean_errcnt", {28'd0, err_count}, 32'd0);

      // Single corruption of 24'h000100: the flipped word misses, and since
      // it seeds the next prediction the following correct word misses too.
      step(1'b1, cur ^ 24'h000001);
      cur = nxt(cur);
      check("corr_err", {31'd0, error}, 32'd1);
      check("corr_cnt1", {28'd0, err_count}, 32'd1);
      check("corr_locked", {31'd0, locked}, 32'd1);
`ifdef NOISE_CHK_BITERR_EN
      check("corr_bits", bit_err_count, 32'd1);
`endif
      feed_good();
      check("corr_err2", {31'd0, error}, 32'd1);
      check("corr_cnt2", {28'd0, err_count}, 32'd2);
      feed_good();
      check("corr_recover", {31'd0, error}, 32'd0);
      check("corr_locked2", {31'd0, locked}, 32'd1);

      // Loss of lock: three wrong words.
      step(1'b1, 24'hABCDEF);
      check("loss_cnt3", {28'd0, err_count}, 32'd3);
      check("loss_lock1", {31'd0, locked}, 32'd1);
      step(1'b1, 24'h123456);
      check("loss_cnt4", {28'd0, err_count}, 32'd4);
      check("loss_lock2", {31'd0, locked}, 32'd1);
      step(1'b1, 24'h0F0F0F);
      check("loss_err", {31'd0, error}, 32'd1);
      check("loss_cnt5", {28'd0, err_count}, 32'd5);
      check("loss_unlock", {31'd0, locked}, 32'd0);
`ifdef NOISE_CHK_BITERR_EN
      check("loss_bits", bit_err_count, 32'd43);
`endif
      err_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         feed_good();
         err_seen |= error;
      end
      check("relock_pre", {31'd0, locked}, 32'd0);
      feed_good();
      err_seen |= error;
      check("relock", {31'd0, locked}, 32'd1);
      check("relock_no_err", {31'd0, err_seen}, 32'd0);
      check("relock_cnt", {28'd0, err_count}, 32'd5);

      // Zero sample while locked (prediction was 24'h010000).
      step(1'b1, 24'h000000);
      check("zl_zero", {31'd0, zero_flag}, 32'd1);
      check("zl_err", {31'd0, error}, 32'd1);
      check("zl_cnt", {28'd0, err_count}, 32'd6);
      check("zl_locked", {31'd0, locked}, 32'd1);
`ifdef NOISE_CHK_BITERR_EN
      check("zl_bits", bit_err_count, 32'd44);
`endif
      check("zl_cur", {8'd0, cur}, 32'h0001_0000);
      feed_good();
      check("zl_next_err", {31'd0, error}, 32'd1);
      check("zl_next_zero", {31'd0, zero_flag}, 32'd0);
      check("zl_next_cnt", {28'd0, err_count}, 32'd7);
      feed_good();
      check("zl_hit", {31'd0, error}, 32'd0);
      check("zl_hold_lock", {31'd0, locked}, 32'd1);

      // Asynchronous reset mid clock-low.
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_locked", {31'd0, locked}, 32'd0);
      check("arst_cnt", {28'd0, err_count}, 32'd0);
`ifdef NOISE_CHK_BITERR_EN
      check("arst_bits", bit_err_count, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Zero sample in SEARCH.
      step(1'b1, 24'h000000);
      check("zs_zero", {31'd0, zero_flag}, 32'd1);
      check("zs_err", {31'd0, error}, 32'd0);
      check("zs_locked", {31'd0, locked}, 32'd0);
      step(1'b0, 24'h000000);
      check("zs_pulse_end", {31'd0, zero_flag}, 32'd0);

      // Enable gaps: only enabled samples count towards lock.
      cur = 24'h000001;
      err_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         held = cur;
         feed_good();
         err_seen |= error;
         check("gap_lock_en", {31'd0, locked}, {31'd0, (i == 4)});
         step(1'b0, held);
         err_seen |= error;
         check("gap_lock_idle", {31'd0, locked}, {31'd0, (i == 4)});
      end
      step(1'b0, 24'h000000);
      err_seen |= error;
      check("gap_zero_idle", {31'd0, zero_flag}, 32'd0);
      check("gap_no_err", {31'd0, err_seen}, 32'd0);
      check("gap_cnt", {28'd0, err_count}, 32'd0);

      // Saturation: two misses per three samples keeps lock; 18 misses
      // must clamp the 4-bit counter at 15 rather than wrap.
      for (int k = 0; k < 9; k++) begin
         step(1'b1, cur ^ 24'h000001);
         cur = nxt(cur);
         feed_good();
         feed_good();
         if (k == 6) begin
            check("sat_cnt14", {28'd0, err_count}, 32'd14);
         end
      end
      check("sat_cnt", {28'd0, err_count}, 32'd15);
      check("sat_locked", {31'd0, locked}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
